// File: rtl/ram_sp_param.sv
// Single-port byte-writable RAM with a clear engine that fills every word with CLR_VAL.
// Latency: read data 1 cycle after cs/rw=1; backpressure: busy=1 during clear, accesses dropped.
module ram_sp_param #(
  parameter int                 DATA_W     = 16,
  parameter int                 ADDR_W     = 4,
  parameter int                 DEPTH      = 2**ADDR_W,
  parameter int                 CLR_ON_RST = 1,
  parameter logic [DATA_W-1:0]  CLR_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     d,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clr,
  output logic [DATA_W-1:0]     o,
  output logic                  o_valid,
  output logic                  busy
);

  localparam int                NB      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                clr_we, wr_en, rd_en, in_range;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign busy     = (state_q == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // clr takes priority over a same-cycle access, which is dropped
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (cs) begin
          rd_en = rw;
          wr_en = !rw && in_range;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // array has no reset; its known state comes from the clear engine
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= CLR_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= rd_en;
      if (rd_en) o <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: default 16-word instance plus a 12-word instance for range checks.
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, rw, clr;
  logic [3:0]  addr;
  logic [15:0] d;
  logic [1:0]  be;
  logic [15:0] o, o2;
  logic        o_valid, o_valid2, busy, busy2;

  int n_cmp = 0;
  int n_err = 0;
  int cnt, cnt2;

  always #5 clk = ~clk;

  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CLR_ON_RST(1), .CLR_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rw(rw), .addr(addr), .d(d), .be(be), .clr(clr),
    .o(o), .o_valid(o_valid), .busy(busy)
  );

  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .CLR_ON_RST(1), .CLR_VAL(16'h0000)) dut12 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rw(rw), .addr(addr), .d(d), .be(be), .clr(clr),
    .o(o2), .o_valid(o_valid2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] v, input logic [1:0] b);
    cs = 1'b1; rw = 1'b0; addr = a; d = v; be = b;
    step();
    cs = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    cs = 1'b1; rw = 1'b1; addr = a;
    step();
    cs = 1'b0;
  endtask

  task automatic count_busy();
    cnt = 0; cnt2 = 0;
    while ((busy || busy2) && cnt < 100) begin
      if (busy)  cnt++;
      if (busy2) cnt2++;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; rw = 1'b0; clr = 1'b0; addr = '0; d = '0; be = 2'b11;
    step();
    step();
    chk("rst_o", o, 16'h0000);
    chk("rst_vld", o_valid, 1'b0);
    chk("rst_busy", busy, 1'b1);

    // 1: power-up clear length, then a read of the top word
    rst_n = 1'b1;
    count_busy();
    chk("clr_len", cnt, 16);
    chk("clr_len12", cnt2, 12);
    rd(4'd15);
    chk("t1_o", o, 16'h0000);
    chk("t1_vld", o_valid, 1'b1);
    step();
    chk("t1_vld_drop", o_valid, 1'b0);

    // 2: boundary addresses, back-to-back reads
    wr(4'd15, 16'hFFFF, 2'b11);
    wr(4'd0,  16'h0000, 2'b11);
    cs = 1'b1; rw = 1'b1; addr = 4'd15;
    step();
    chk("t2_o15", o, 16'hFFFF);
    chk("t2_vld15", o_valid, 1'b1);
    addr = 4'd0;
    step();
    cs = 1'b0;
    chk("t2_o0", o, 16'h0000);
    chk("t2_vld0", o_valid, 1'b1);

    // 3: byte enables
    wr(4'd3, 16'hABCD, 2'b11);
    chk("t3_wr_vld", o_valid, 1'b0);
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3);
    chk("t3_o", o, 16'hAB34);
    wr(4'd3, 16'h9900, 2'b10);
    rd(4'd3);
    chk("t3_hi", o, 16'h9934);

    // 4: cs=0 does nothing
    cs = 1'b0; rw = 1'b0; addr = 4'd5; d = 16'h5555; be = 2'b11;
    step();
    chk("t4_hold", o, 16'h9934);
    chk("t4_vld", o_valid, 1'b0);
    rd(4'd5);
    chk("t4_mem5", o, 16'h0000);
    rd(4'd3);
    chk("t4_o3", o, 16'h9934);

    // 5: clr with simultaneous write; accesses during busy are ignored
    cs = 1'b1; rw = 1'b0; addr = 4'd2; d = 16'h7777; be = 2'b11; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_busy", busy, 1'b1);
    cnt = 0;
    addr = 4'd4; d = 16'hFFFF;
    while (busy && cnt < 100) begin
      rw = cnt[0];
      step();
      cnt++;
      if (busy) begin
        chk("t5_hold", o, 16'h9934);
        chk("t5_vld", o_valid, 1'b0);
      end
    end
    cs = 1'b0;
    chk("t5_len", cnt, 16);
    cs = 1'b1; rw = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      step();
      chk($sformatf("t5_rd%0d", a), {o_valid, o}, {1'b1, 16'h0000});
    end
    cs = 1'b0;

    // 6: reset in the middle of a clear
    wr(4'd1, 16'h1234, 2'b11);
    rd(4'd1);
    chk("t6_pre", o, 16'h1234);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_o", o, 16'h0000);
    chk("t6_rst_vld", o_valid, 1'b0);
    step();
    rst_n = 1'b1;
    count_busy();
    chk("t6_len", cnt, 16);
    chk("t6_len12", cnt2, 12);

    // 12-word instance: in-range works, out-of-range write dropped and reads 0
    wr(4'd11, 16'h4242, 2'b11);
    rd(4'd11);
    chk("d12_o11", o2, 16'h4242);
    wr(4'd13, 16'hBEEF, 2'b11);
    rd(4'd13);
    chk("d12_o13", o2, 16'h0000);
    chk("d12_vld13", o_valid2, 1'b1);
    chk("d16_o13", o, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
